decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// Registered RV32I decode stage between fetch and execute. Accepts one instruction and PC per
// valid/ready beat, decodes control flags, register indices and the sign-extended immediate,
// and flags illegal encodings. A 2-entry skid buffer keeps in_ready registered. Saturating
// counters for decoded and illegal instructions are exposed for the performance/debug block.
// PARAMETERS
// XLEN          32  datapath width for the pc and imm outputs (>=32; imm sign-extended to XLEN)
// CNT_W         16  width of the decoded and illegal counters (saturating)
// RD0_SUPPRESS  1   1: force regWrite=0 when rd==x0; 0: regWrite follows the opcode only
// PORTS
// clk            in   1      clock, rising edge
// reset          in   1      synchronous reset, active-high
// flush          in   1      drop every buffered entry (branch redirect)
// in_valid       in   1      upstream beat valid
// in_ready       out  1      stage can accept (registered)
// in_instr       in   32     instruction word
// in_pc          in   XLEN   PC of in_instr
// out_valid      out  1      decoded beat valid
// out_ready      in   1      downstream accepts
// out_pc         out  XLEN   PC passthrough
// out_ctrl       out  10     {ALUreg,ALUimm,Branch,JAL,JALR,LUI,AUIPC,Load,Store,regWrite}
// out_rd/rs1/rs2 out  5 each register indices from instr[11:7]/[19:15]/[24:20]
// out_funct3     out  3      instr[14:12]
// out_funct7b5   out  1      instr[30]
// out_imm        out  XLEN   I/S/B/U/J immediate chosen by opcode; 0 for R-type/illegal
// out_illegal    out  1      beat carries an illegal encoding
// cnt_decoded    out  CNT_W  count of beats accepted downstream (out_valid&&out_ready)
// cnt_illegal    out  CNT_W  count of those beats with out_illegal=1
// BEHAVIOUR
// - Reset: in_ready=1 on the first cycle after reset; out_valid=0; every out_* data field=0;
//   both counters=0; skid entry empty.
// - Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N when the main
//   register is free.
// - Handshake: transfer when valid&&ready. out_* stays stable while out_valid && !out_ready.
//   in_valid is never required to wait on in_ready.
// - Skid: main reg M, skid reg S. Accept with M empty or draining -> load M. Accept with M held
//   -> load S, so in_ready drops next cycle. When M drains and S is full, S moves to M and
//   in_ready rises. in_ready = !S_full.
// - States (occupancy): EMPTY(0) -> ONE(1) -> FULL(2). FULL+drain -> ONE; ONE+drain+no accept
//   -> EMPTY; accept+drain in the same cycle leaves occupancy unchanged.
// - Decode (opcode instr[6:2], instr[1:0] must be 2'b11):
//   01100 ALUreg; 00100 ALUimm; 00000 Load; 01000 Store; 11000 Branch; 11001 JALR; 11011 JAL;
//   01101 LUI; 00101 AUIPC.
//   regWrite=1 for ALUreg/ALUimm/Load/JALR/JAL/LUI/AUIPC, 0 for Store/Branch.
// - Illegal when any of: instr[1:0]!=2'b11; unknown opcode; Branch funct3 in {010,011};
//   Load funct3 in {011,110,111}; Store funct3>=011; JALR funct3!=000. An illegal beat forces
//   out_ctrl=0 and out_imm=0, keeps rd/rs/funct fields raw and still transfers (no stall).
// - imm: I={{20{i[31]}},i[31:20]}, S={..,i[31:25],i[11:7]}, B={..,i[7],i[30:25],i[11:8],0},
//   U={i[31:12],12'b0}, J={..,i[19:12],i[20],i[30:21],0}; sign-extended to XLEN.
// - flush: M and S clear, out_valid=0 on the next cycle, in_ready=1. A same-cycle in_valid beat
//   is dropped. A same-cycle downstream transfer still counts.
// - reset overrides flush. Reset in mid-stream discards both entries; counters return to 0.
// - Counters increment on the downstream transfer and hold at 2^CNT_W-1.
// STRUCTURE
// - decoder_pkg: opcode localparams, CTRL_* bit-index constants, funct3 legality constants.
// - Sub-module decode_comb: purely combinational 32-bit instr -> {ctrl, imm, illegal}, XLEN
//   parameter. Decode runs on the input side so M and S hold decoded fields.
// - Top: skid control, M/S registers, counters.
// TESTING
// - Reset, then add x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1,
//   ctrl=10'b1000000001, rd=3, rs1=1, rs2=2.
// - Burst addi/lw/sw/beq/jalr/jal/lui/auipc back-to-back with out_ready=1 -> one per cycle;
//   ctrl matches the opcode table; regWrite=0 for sw and beq; cnt_decoded=8.
// - Backpressure: out_ready=0 over 3 beats -> in_ready=0 after 2 accepted. Releasing
//   out_ready -> beats emerge in order, none lost or duplicated.
// - Immediates: beq offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC; lui 0x12345 -> imm=0x12345000;
//   sw 4(x1) -> imm=4.
// - Illegal: 0x00000000 and 0x0000A067 (jalr funct3=010) -> out_illegal=1, ctrl=0,
//   cnt_illegal increments. addi rd=x0 with RD0_SUPPRESS=1 -> regWrite=0.
// - flush while FULL -> out_valid=0 and in_ready=1 next cycle. Reset asserted together with
//   flush and in_valid -> all outputs at reset values and counters at 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared constants for the RV32I decode stage: opcode values (instr[6:2]),
//   bit positions inside the 10-bit control vector, funct3 legality helpers
//   and the occupancy state type of the skid buffer.
package decoder_pkg;

  localparam logic [4:0] OP_ALUREG = 5'b01100;
  localparam logic [4:0] OP_ALUIMM = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  // Control vector is {ALUreg,ALUimm,Branch,JAL,JALR,LUI,AUIPC,Load,Store,regWrite}
  localparam int CTRL_W        = 10;
  localparam int CTRL_ALUREG   = 9;
  localparam int CTRL_ALUIMM   = 8;
  localparam int CTRL_BRANCH   = 7;
  localparam int CTRL_JAL      = 6;
  localparam int CTRL_JALR     = 5;
  localparam int CTRL_LUI      = 4;
  localparam int CTRL_AUIPC    = 3;
  localparam int CTRL_LOAD     = 2;
  localparam int CTRL_STORE    = 1;
  localparam int CTRL_REGWRITE = 0;

  localparam logic [2:0] F3_BRANCH_RSV0 = 3'b010;
  localparam logic [2:0] F3_BRANCH_RSV1 = 3'b011;
  localparam logic [2:0] F3_LOAD_RSV0   = 3'b011;
  localparam logic [2:0] F3_LOAD_RSV1   = 3'b110;
  localparam logic [2:0] F3_LOAD_RSV2   = 3'b111;
  localparam logic [2:0] F3_STORE_MAX   = 3'b010;
  localparam logic [2:0] F3_JALR        = 3'b000;

  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3 != F3_BRANCH_RSV0) && (f3 != F3_BRANCH_RSV1);
  endfunction

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 != F3_LOAD_RSV0) && (f3 != F3_LOAD_RSV1) && (f3 != F3_LOAD_RSV2);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return f3 <= F3_STORE_MAX;
  endfunction

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/decode_comb.sv
// decode_comb
//   Purely combinational RV32I instruction decoder.
//   instr   in  32          instruction word
//   ctrl    out CTRL_W      control flags (zero for illegal encodings)
//   imm     out XLEN        sign-extended immediate (zero for R-type/illegal)
//   illegal out 1           encoding is not a supported RV32I instruction
module decode_comb
  import decoder_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit RD0_SUPPRESS = 1'b1
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  logic [4:0]        opcode;
  logic [2:0]        funct3;
  logic [CTRL_W-1:0] ctrl_raw;
  logic [31:0]       imm32;
  logic              bad;

  assign opcode = instr[6:2];
  assign funct3 = instr[14:12];

  always_comb begin
    ctrl_raw = '0;
    imm32    = '0;
    bad      = 1'b0;
    unique case (opcode)
      OP_ALUREG: begin
        ctrl_raw[CTRL_ALUREG]   = 1'b1;
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
      end
      OP_ALUIMM: begin
        ctrl_raw[CTRL_ALUIMM]   = 1'b1;
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LOAD: begin
        ctrl_raw[CTRL_LOAD]     = 1'b1;
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
        bad   = !load_f3_ok(funct3);
      end
      OP_STORE: begin
        ctrl_raw[CTRL_STORE] = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        bad   = !store_f3_ok(funct3);
      end
      OP_BRANCH: begin
        ctrl_raw[CTRL_BRANCH] = 1'b1;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        bad   = !branch_f3_ok(funct3);
      end
      OP_JALR: begin
        ctrl_raw[CTRL_JALR]     = 1'b1;
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
        bad   = (funct3 != F3_JALR);
      end
      OP_JAL: begin
        ctrl_raw[CTRL_JAL]      = 1'b1;
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_LUI: begin
        ctrl_raw[CTRL_LUI]      = 1'b1;
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        ctrl_raw[CTRL_AUIPC]    = 1'b1;
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        imm32 = {instr[31:12], 12'b0};
      end
      default: bad = 1'b1;
    endcase

    // Compressed/short encodings are never legal here.
    if (instr[1:0] != 2'b11) bad = 1'b1;

    // Writes to x0 are architecturally discarded; hide them from the hazard logic.
    if (RD0_SUPPRESS && (instr[11:7] == 5'd0)) ctrl_raw[CTRL_REGWRITE] = 1'b0;
  end

  assign illegal = bad;
  assign ctrl    = bad ? '0 : ctrl_raw;
  assign imm     = bad ? '0 : XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered RV32I decode stage with a 2-entry skid buffer (main M, skid S).
//   clk, reset          clock and synchronous active-high reset
//   flush               drop all buffered entries
//   in_valid/in_ready   upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready downstream handshake
//   out_pc, out_ctrl, out_rd, out_rs1, out_rs2, out_funct3, out_funct7b5,
//   out_imm, out_illegal  decoded fields of the beat held in M
//   cnt_decoded, cnt_illegal  saturating downstream transfer counters
module decode_stage
  import decoder_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 16,
  parameter bit RD0_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [2:0]        out_funct3,
  output logic              out_funct7b5,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  cnt_decoded,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam int PAY_W = 2 * XLEN + CTRL_W + 15 + 3 + 1 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;
  logic [PAY_W-1:0]  in_pay;

  occ_e             state_q, state_d;
  logic [PAY_W-1:0] m_pay_q, m_pay_d;
  logic [PAY_W-1:0] s_pay_q, s_pay_d;
  logic [CNT_W-1:0] cnt_dec_q, cnt_dec_d;
  logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;
  logic             accept, drain;

  decode_comb #(
    .XLEN         (XLEN),
    .RD0_SUPPRESS (RD0_SUPPRESS)
  ) u_decode (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Decode happens before buffering so M and S carry ready-to-use fields.
  assign in_pay = {in_pc, dec_ctrl, in_instr[11:7], in_instr[19:15], in_instr[24:20],
                   in_instr[14:12], in_instr[30], dec_imm, dec_illegal};

  assign {out_pc, out_ctrl, out_rd, out_rs1, out_rs2,
          out_funct3, out_funct7b5, out_imm, out_illegal} = m_pay_q;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= OCC_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: if (accept) state_d = OCC_ONE;
      OCC_ONE: begin
        if (drain && !accept)      state_d = OCC_EMPTY;
        else if (!drain && accept) state_d = OCC_FULL;
      end
      OCC_FULL:  if (drain) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
    if (flush) state_d = OCC_EMPTY;
  end

  // S is only ever occupied while M is, so both flags follow from occupancy.
  always_comb begin
    out_valid = (state_q != OCC_EMPTY);
    in_ready  = (state_q != OCC_FULL);
  end

  always_comb begin
    m_pay_d   = m_pay_q;
    s_pay_d   = s_pay_q;
    cnt_dec_d = cnt_dec_q;
    cnt_ill_d = cnt_ill_q;

    // A transfer in the flush cycle really happened downstream, so it still counts.
    if (drain) begin
      if (cnt_dec_q != CNT_MAX) cnt_dec_d = cnt_dec_q + CNT_W'(1);
      if (out_illegal && (cnt_ill_q != CNT_MAX)) cnt_ill_d = cnt_ill_q + CNT_W'(1);
    end

    if (flush) begin
      m_pay_d = '0;
      s_pay_d = '0;
    end else if (drain || !out_valid) begin
      // M is free this cycle: refill from S first to keep order, else from input.
      if (state_q == OCC_FULL) m_pay_d = s_pay_q;
      else if (accept)         m_pay_d = in_pay;
    end else if (accept) begin
      s_pay_d = in_pay;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_pay_q   <= '0;
      s_pay_q   <= '0;
      cnt_dec_q <= '0;
      cnt_ill_q <= '0;
    end else begin
      m_pay_q   <= m_pay_d;
      s_pay_q   <= s_pay_d;
      cnt_dec_q <= cnt_dec_d;
      cnt_ill_q <= cnt_ill_d;
    end
  end

  assign cnt_decoded = cnt_dec_q;
  assign cnt_illegal = cnt_ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed bench for decode_stage. Counters are built 4 bits wide so the
//   saturation point is reachable with a short vector list.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset, flush, inValid, outReady;
  logic              inReady, outValid;
  logic [31:0]       inInstr;
  logic [XLEN-1:0]   inPc;
  logic [XLEN-1:0]   outPc, outImm;
  logic [9:0]        outCtrl;
  logic [4:0]        outRd, outRs1, outRs2;
  logic [2:0]        outFunct3;
  logic              outFunct7b5, outIllegal;
  logic [CNT_W-1:0]  cntDecoded, cntIllegal;

  int testsRun    = 0;
  int testsFailed = 0;

  localparam logic [31:0] ADD_X3 = 32'h002081B3;

  logic [31:0] burstInstr [8] = '{32'h00700293, 32'h0080A303, 32'h0020A223, 32'hFE000EE3,
                                  32'h000280E7, 32'h008000EF, 32'h123453B7, 32'h00001417};
  logic [31:0] burstCtrl  [8] = '{32'h101, 32'h005, 32'h002, 32'h080,
                                  32'h021, 32'h041, 32'h011, 32'h009};
  logic [31:0] burstImm   [8] = '{32'h7, 32'h8, 32'h4, 32'hFFFFFFFC,
                                  32'h0, 32'h8, 32'h12345000, 32'h1000};

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN         (XLEN),
    .CNT_W        (CNT_W),
    .RD0_SUPPRESS (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_instr     (inInstr),
    .in_pc        (inPc),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_pc       (outPc),
    .out_ctrl     (outCtrl),
    .out_rd       (outRd),
    .out_rs1      (outRs1),
    .out_rs2      (outRs2),
    .out_funct3   (outFunct3),
    .out_funct7b5 (outFunct7b5),
    .out_imm      (outImm),
    .out_illegal  (outIllegal),
    .cnt_decoded  (cntDecoded),
    .cnt_illegal  (cntIllegal)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle before checking.
  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic rdy,
                               input logic [31:0] instr, input logic [31:0] pc);
    reset    = r;
    flush    = f;
    inValid  = v;
    outReady = rdy;
    inInstr  = instr;
    inPc     = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inInstr = '0; inPc = '0;

    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_ctrl", 32'(outCtrl), 32'd0);
    checkOutput("reset_imm", outImm, 32'd0);
    checkOutput("reset_pc", outPc, 32'd0);
    checkOutput("reset_cnt_dec", 32'(cntDecoded), 32'd0);

    // Single add beat, one cycle latency
    applyStimulus(0, 0, 1, 1, ADD_X3, 32'h100);
    checkOutput("add_valid", 32'(outValid), 32'd1);
    checkOutput("add_ctrl", 32'(outCtrl), 32'h201);
    checkOutput("add_rd", 32'(outRd), 32'd3);
    checkOutput("add_rs1", 32'(outRs1), 32'd1);
    checkOutput("add_rs2", 32'(outRs2), 32'd2);
    checkOutput("add_pc", outPc, 32'h100);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    checkOutput("add_drained", 32'(outValid), 32'd0);
    checkOutput("add_cnt", 32'(cntDecoded), 32'd1);

    // Reset clears the counters again before the burst
    applyStimulus(1, 0, 0, 1, 32'h0, 32'h0);
    checkOutput("rst2_cnt", 32'(cntDecoded), 32'd0);

    // Burst of eight different opcodes, one per cycle
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 1, 1, burstInstr[k], 32'h200 + 32'(4 * k));
      checkOutput($sformatf("burst%0d_valid", k), 32'(outValid), 32'd1);
      checkOutput($sformatf("burst%0d_ctrl", k), 32'(outCtrl), burstCtrl[k]);
      checkOutput($sformatf("burst%0d_imm", k), outImm, burstImm[k]);
      checkOutput($sformatf("burst%0d_pc", k), outPc, 32'h200 + 32'(4 * k));
      checkOutput($sformatf("burst%0d_ill", k), 32'(outIllegal), 32'd0);
    end
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    checkOutput("burst_cnt", 32'(cntDecoded), 32'd8);
    checkOutput("burst_empty", 32'(outValid), 32'd0);

    // Backpressure: A into M, B into S, C refused until a slot frees
    applyStimulus(0, 0, 1, 0, ADD_X3, 32'h300);
    checkOutput("bp_a_valid", 32'(outValid), 32'd1);
    checkOutput("bp_a_ready", 32'(inReady), 32'd1);
    applyStimulus(0, 0, 1, 0, ADD_X3, 32'h304);
    checkOutput("bp_b_ready", 32'(inReady), 32'd0);
    checkOutput("bp_b_pc", outPc, 32'h300);
    applyStimulus(0, 0, 1, 0, ADD_X3, 32'h308);
    checkOutput("bp_c_ready", 32'(inReady), 32'd0);
    checkOutput("bp_c_stable", outPc, 32'h300);
    applyStimulus(0, 0, 1, 1, ADD_X3, 32'h308);
    checkOutput("bp_rel_pc_b", outPc, 32'h304);
    checkOutput("bp_rel_ready", 32'(inReady), 32'd1);
    applyStimulus(0, 0, 1, 1, ADD_X3, 32'h308);
    checkOutput("bp_pc_c", outPc, 32'h308);
    checkOutput("bp_c_valid", 32'(outValid), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    checkOutput("bp_empty", 32'(outValid), 32'd0);
    checkOutput("bp_cnt", 32'(cntDecoded), 32'd11);

    // Illegal encodings transfer with zeroed ctrl/imm and raw fields
    applyStimulus(0, 0, 1, 1, 32'h00000000, 32'h400);
    checkOutput("ill0_flag", 32'(outIllegal), 32'd1);
    checkOutput("ill0_ctrl", 32'(outCtrl), 32'd0);
    checkOutput("ill0_imm", outImm, 32'd0);
    applyStimulus(0, 0, 1, 1, 32'h0000A067, 32'h404);
    checkOutput("ill1_flag", 32'(outIllegal), 32'd1);
    checkOutput("ill1_ctrl", 32'(outCtrl), 32'd0);
    checkOutput("ill1_rs1", 32'(outRs1), 32'd1);
    checkOutput("ill1_funct3", 32'(outFunct3), 32'd2);
    applyStimulus(0, 0, 1, 1, 32'h00100013, 32'h408);
    checkOutput("rd0_ctrl", 32'(outCtrl), 32'h100);
    checkOutput("rd0_imm", outImm, 32'd1);
    checkOutput("rd0_ill", 32'(outIllegal), 32'd0);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    checkOutput("ill_cnt", 32'(cntIllegal), 32'd2);
    checkOutput("ill_cnt_dec", 32'(cntDecoded), 32'd14);

    // Flush while FULL drops both entries and the same-cycle input beat
    applyStimulus(0, 0, 1, 0, ADD_X3, 32'h500);
    applyStimulus(0, 0, 1, 0, ADD_X3, 32'h504);
    checkOutput("fl_full", 32'(inReady), 32'd0);
    applyStimulus(0, 1, 1, 0, ADD_X3, 32'h508);
    checkOutput("fl_valid", 32'(outValid), 32'd0);
    checkOutput("fl_ready", 32'(inReady), 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("fl_dropped", 32'(outValid), 32'd0);
    checkOutput("fl_cnt", 32'(cntDecoded), 32'd14);

    // A downstream transfer coinciding with flush is still counted
    applyStimulus(0, 0, 1, 1, ADD_X3, 32'h600);
    applyStimulus(0, 1, 0, 1, 32'h0, 32'h0);
    checkOutput("fl2_valid", 32'(outValid), 32'd0);
    checkOutput("fl2_cnt", 32'(cntDecoded), 32'd15);

    // Counter holds at its maximum
    applyStimulus(0, 0, 1, 1, ADD_X3, 32'h604);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    checkOutput("sat_cnt", 32'(cntDecoded), 32'd15);

    // Reset wins over flush and a same-cycle input beat
    applyStimulus(0, 0, 1, 0, ADD_X3, 32'h700);
    applyStimulus(1, 1, 1, 0, ADD_X3, 32'h704);
    checkOutput("rf_valid", 32'(outValid), 32'd0);
    checkOutput("rf_ready", 32'(inReady), 32'd1);
    checkOutput("rf_ctrl", 32'(outCtrl), 32'd0);
    checkOutput("rf_pc", outPc, 32'd0);
    checkOutput("rf_rd", 32'(outRd), 32'd0);
    checkOutput("rf_cnt_dec", 32'(cntDecoded), 32'd0);
    checkOutput("rf_cnt_ill", 32'(cntIllegal), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
